popcount_fold_acc: RTL and testbench

- Parametrised, folded (time-multiplexed) popcount for ternary-neuron datapaths. It generalises the fixed 22-input combinational popcount to any WIDTH.
- Each accepted WIDTH-bit vector is split into CHUNK_W-bit chunks. One chunk is counted per cycle, and the chunk counts are accumulated.
- A run-time approximation mode drops the low APPROX_DROP bits of every chunk. This trades accuracy for switching activity, with a bounded worst-case error.
- Sits between the sensor-side input register and the neuron threshold/activation stage, using valid/ready on both sides.

---
 rtl/popcount_pkg.sv | 36 +++
 rtl/popcount_chunk.sv | 27 ++
 rtl/popcount_fold_acc.sv | 108 ++++++++++
 tb/tb_popcount_fold_acc.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_pkg.sv
// Shared types and elaboration-time sizing helpers for the folded popcount.
package popcount_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Smallest r with 2**r >= v; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned nchunk(input int unsigned width, input int unsigned chunk_w);
        return (width + chunk_w - 1) / chunk_w;
    endfunction

    function automatic int unsigned out_w(input int unsigned width);
        return clog2(width + 1);
    endfunction

    // Index counter width; at least one bit even for a single chunk.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational popcount of one masked chunk, built as a balanced adder tree.
module popcount_chunk
    import popcount_pkg::*;
#(
    parameter  int unsigned CHUNK_W = 8,
    localparam int unsigned CNT_W   = clog2(CHUNK_W + 1)
) (
    input  logic [CHUNK_W-1:0] chunk,
    input  logic [CHUNK_W-1:0] mask,
    output logic [CNT_W-1:0]   count_c
);

    // Heap layout: leaves at [CHUNK_W, 2*CHUNK_W-1], node i sums children 2i and 2i+1, root is node 1.
    logic [CNT_W-1:0] node [1:2*CHUNK_W-1];

    always_comb begin
        for (int i = 0; i < int'(CHUNK_W); i++) begin
            node[int'(CHUNK_W) + i] = CNT_W'(chunk[i] & mask[i]);
        end
        for (int i = int'(CHUNK_W) - 1; i >= 1; i--) begin
            node[i] = node[2*i] + node[2*i+1];
        end
    end

    assign count_c = node[1];

endmodule

// File: rtl/popcount_fold_acc.sv
// Folded popcount: one CHUNK_W slice per cycle accumulated over NCHUNK cycles,
// with optional low-bit dropping per chunk and valid/ready on both sides.
module popcount_fold_acc
    import popcount_pkg::*;
#(
    parameter  int unsigned WIDTH       = 22,
    parameter  int unsigned CHUNK_W     = 8,
    parameter  int unsigned APPROX_DROP = 2,
    localparam int unsigned NCHUNK      = nchunk(WIDTH, CHUNK_W),
    localparam int unsigned OUT_W       = out_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic             approx_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] popcount_out,
    output logic             out_approx
);

    localparam int unsigned CNT_W = clog2(CHUNK_W + 1);
    localparam int unsigned PAD_W = NCHUNK * CHUNK_W;
    localparam int unsigned IDX_W = idx_w(NCHUNK);

    localparam logic [IDX_W-1:0]   LAST_IDX    = IDX_W'(NCHUNK - 1);
    localparam logic [CHUNK_W-1:0] APPROX_MASK = {CHUNK_W{1'b1}} << APPROX_DROP;

    state_t             state;
    logic [PAD_W-1:0]   sreg;
    logic [PAD_W-1:0]   sreg_shift;
    logic [OUT_W-1:0]   acc;
    logic [IDX_W-1:0]   idx;
    logic               approx_q;

    logic [CHUNK_W-1:0] mask_c;
    logic [CNT_W-1:0]   chunk_cnt_c;
    logic [OUT_W-1:0]   sum_c;
    logic               in_fire_c;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign in_fire_c = in_valid & in_ready;

    assign mask_c = approx_q ? APPROX_MASK : {CHUNK_W{1'b1}};
    // Chunk count never exceeds WIDTH, so the OUT_W accumulator cannot wrap.
    assign sum_c  = acc + OUT_W'(chunk_cnt_c);

    // The current chunk always sits in the low CHUNK_W bits; the rest shifts down behind it.
    if (NCHUNK > 1) begin : g_shift
        assign sreg_shift = {{CHUNK_W{1'b0}}, sreg[PAD_W-1:CHUNK_W]};
    end else begin : g_no_shift
        assign sreg_shift = '0;
    end

    popcount_chunk #(
        .CHUNK_W (CHUNK_W)
    ) u_chunk (
        .chunk   (sreg[CHUNK_W-1:0]),
        .mask    (mask_c),
        .count_c (chunk_cnt_c)
    );

    // Control FSM with registered result; a new input transfer overrides the state update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sreg         <= '0;
            acc          <= '0;
            idx          <= '0;
            approx_q     <= 1'b0;
            popcount_out <= '0;
            out_approx   <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    acc  <= sum_c;
                    sreg <= sreg_shift;
                    idx  <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        popcount_out <= sum_c;
                        out_approx   <= approx_q;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (in_fire_c) begin
                sreg     <= PAD_W'(input_a);
                approx_q <= approx_en;
                acc      <= '0;
                idx      <= '0;
                state    <= ACC;
            end
        end
    end

endmodule

// File: tb/tb_popcount_fold_acc.sv
// Bench for popcount_fold_acc: directed table, handshake/reset corners, and a
// randomized sweep on the default build and a single-chunk build.
module tb_popcount_fold_acc;

    localparam int unsigned W   = 22;
    localparam int unsigned CW  = 8;
    localparam int unsigned AD  = 2;
    localparam int unsigned WCE = 6;
    localparam int unsigned SW  = 7;
    localparam int unsigned SCW = 7;
    localparam int unsigned SAD = 0;
    localparam int          NVEC = 5000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic          in_valid, in_ready, approx_en, out_valid, out_ready, out_approx;
    logic [W-1:0]  input_a;
    logic [4:0]    popcount_out;

    logic          s_in_valid, s_in_ready, s_approx_en, s_out_valid, s_out_ready, s_out_approx;
    logic [SW-1:0] s_input_a;
    logic [2:0]    s_popcount_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] a;
        logic         ax;
        int           exp_cnt;
    } vec_t;

    typedef struct {
        int   cnt;
        int   exact;
        logic ax;
    } exp_t;

    vec_t tbl [0:9];
    exp_t m_q [$];
    exp_t s_q [$];
    exp_t m_e, m_p, s_e, s_p;

    bit   sweep_on = 1'b0;
    int   acc_main = 0;
    int   acc_small = 0;
    bit   m_stall = 1'b0;
    bit   s_stall = 1'b0;
    int   m_held, s_held;
    logic m_held_ax, s_held_ax;

    always #5 clk = ~clk;

    popcount_fold_acc #(.WIDTH(W), .CHUNK_W(CW), .APPROX_DROP(AD)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .input_a      (input_a),
        .approx_en    (approx_en),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .popcount_out (popcount_out),
        .out_approx   (out_approx)
    );

    popcount_fold_acc #(.WIDTH(SW), .CHUNK_W(SCW), .APPROX_DROP(SAD)) u_dut_small (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (s_in_valid),
        .in_ready     (s_in_ready),
        .input_a      (s_input_a),
        .approx_en    (s_approx_en),
        .out_valid    (s_out_valid),
        .out_ready    (s_out_ready),
        .popcount_out (s_popcount_out),
        .out_approx   (s_out_approx)
    );

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: count set bits, skipping bit positions whose offset inside
    // their chunk is below the drop amount when approximating.
    function automatic int ref_count(input logic [31:0] v, input int width, input int cw,
                                     input int drop, input logic ax);
        int c;
        c = 0;
        for (int i = 0; i < width; i++) begin
            if (v[i] && !(ax && ((i % cw) < drop))) c++;
        end
        return c;
    endfunction

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic send_vec(input logic [W-1:0] a, input logic ax, input int exp, input string nm);
        int lat;
        check({nm, "_in_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        input_a   = a;
        approx_en = ax;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        input_a   = W'($urandom);
        approx_en = ~ax;
        wait_out(lat);
        check({nm, "_latency"}, lat, 3);
        check({nm, "_count"}, popcount_out, exp);
        check({nm, "_approx"}, out_approx, ax);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_valid_drop"}, out_valid, 0);
        check({nm, "_count_kept"}, popcount_out, exp);
    endtask

    task automatic drive_main(input int nvec);
        int cyc;
        cyc = 0;
        while (acc_main < nvec && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            input_a   = W'($urandom);
            approx_en = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("main_sweep_complete", acc_main >= nvec, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drive_small(input int nvec);
        int cyc;
        cyc = 0;
        while (acc_small < nvec && cyc < 60000) begin
            s_in_valid  = ($urandom_range(0, 2) != 0);
            s_input_a   = SW'($urandom);
            s_approx_en = 1'($urandom);
            s_out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
            cyc++;
        end
        check("small_sweep_complete", acc_small >= nvec, 1);
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard for the default build, sampled mid-cycle.
    always @(negedge clk) begin
        if (sweep_on) begin
            if (m_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_value", popcount_out, m_held);
                check("hold_approx", out_approx, m_held_ax);
            end
            if (out_valid && out_ready) begin
                if (m_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    m_p = m_q.pop_front();
                    check("sweep_count", popcount_out, m_p.cnt);
                    check("sweep_approx", out_approx, m_p.ax);
                    if (m_p.ax)
                        check("wce_bound", (int'(popcount_out) <= m_p.exact) &&
                                           (int'(popcount_out) + int'(WCE) >= m_p.exact), 1);
                end
            end
            m_stall   = out_valid && !out_ready;
            m_held    = int'(popcount_out);
            m_held_ax = out_approx;
            if (in_valid && in_ready) begin
                m_e.cnt   = ref_count(32'(input_a), W, CW, AD, approx_en);
                m_e.exact = ref_count(32'(input_a), W, CW, AD, 1'b0);
                m_e.ax    = approx_en;
                m_q.push_back(m_e);
                acc_main++;
            end
        end
    end

    // Scoreboard for the single-chunk build; approx mode must equal exact here.
    always @(negedge clk) begin
        if (sweep_on) begin
            if (s_stall) begin
                check("s_hold_valid", s_out_valid, 1);
                check("s_hold_value", s_popcount_out, s_held);
                check("s_hold_approx", s_out_approx, s_held_ax);
            end
            if (s_out_valid && s_out_ready) begin
                if (s_q.size() == 0) begin
                    check("s_unexpected_output", 1, 0);
                end else begin
                    s_p = s_q.pop_front();
                    check("s_sweep_count", s_popcount_out, s_p.exact);
                    check("s_sweep_approx", s_out_approx, s_p.ax);
                end
            end
            s_stall   = s_out_valid && !s_out_ready;
            s_held    = int'(s_popcount_out);
            s_held_ax = s_out_approx;
            if (s_in_valid && s_in_ready) begin
                s_e.cnt   = ref_count(32'(s_input_a), SW, SCW, SAD, s_approx_en);
                s_e.exact = ref_count(32'(s_input_a), SW, SCW, SAD, 1'b0);
                s_e.ax    = s_approx_en;
                s_q.push_back(s_e);
                acc_small++;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        in_valid    = 1'b0; approx_en   = 1'b0; out_ready   = 1'b0; input_a   = '0;
        s_in_valid  = 1'b0; s_approx_en = 1'b0; s_out_ready = 1'b0; s_input_a = '0;

        tbl[0] = '{22'h3FFFFF, 1'b0, 22};
        tbl[1] = '{22'h3FFFFF, 1'b1, 16};
        tbl[2] = '{22'h000001, 1'b1, 0};
        tbl[3] = '{22'h000001, 1'b0, 1};
        tbl[4] = '{22'h155555, 1'b0, 11};
        tbl[5] = '{22'h2AAAAA, 1'b1, 8};
        tbl[6] = '{22'h300000, 1'b1, 2};
        tbl[7] = '{22'h030303, 1'b1, 0};
        tbl[8] = '{22'h030303, 1'b0, 6};
        tbl[9] = '{22'h000000, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_popcount", popcount_out, 0);
        check("rst_out_approx", out_approx, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_small_out_valid", s_out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            send_vec(tbl[i].a, tbl[i].ax, tbl[i].exp_cnt, $sformatf("tbl%0d", i));
        end

        // Downstream stall: result held, input side closed, in_valid pulses ignored.
        in_valid = 1'b1; input_a = 22'h3FFFFF; approx_en = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        check("stall_latency", lat, 3);
        for (int k = 0; k < 5; k++) begin
            in_valid  = k[0];
            input_a   = W'($urandom);
            approx_en = 1'b1;
            @(posedge clk); #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            check("stall_popcount", popcount_out, 22);
            check("stall_out_approx", out_approx, 0);
        end

        // Back-to-back: release the result and hand over a new vector on the same edge.
        in_valid = 1'b1; input_a = 22'h155555; approx_en = 1'b0; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_valid_drop", out_valid, 0);
        wait_out(lat);
        check("b2b_latency", lat, 3);
        check("b2b_count", popcount_out, 11);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Asynchronous reset in the middle of accumulation.
        in_valid = 1'b1; input_a = 22'h3FFFFF; approx_en = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_popcount", popcount_out, 0);
        check("arst_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("arst_no_output", out_valid, 0);
        send_vec(22'h00000F, 1'b0, 4, "post_rst");

        // Randomized sweep on both builds in parallel.
        sweep_on = 1'b1;
        fork
            drive_main(NVEC);
            drive_small(NVEC);
        join
        @(negedge clk);
        sweep_on = 1'b0;
        check("main_drain", m_q.size(), 0);
        check("small_drain", s_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
